// File: rtl/sonic_vc_pkg.sv
// sonic_vc_pkg
// Shared definitions for the SONIC virtual-channel classifier:
//   - stream widths (data, BAR decode, byte enables)
//   - classifier state enum
//   - packed beat record carried through the output register
//   - BAR-mask hit helper used for start-of-packet classification
package sonic_vc_pkg;

  localparam int SONIC_VC_DATA_W   = 128;
  localparam int SONIC_VC_BARDEC_W = 8;
  localparam int SONIC_VC_BE_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } sonic_vc_cls_state_t;

  typedef struct packed {
    logic [SONIC_VC_DATA_W-1:0]   data;
    logic                         empty;
    logic                         eop;
    logic                         sop;
    logic [SONIC_VC_BARDEC_W-1:0] bardec;
    logic [SONIC_VC_BE_W-1:0]     be;
  } sonic_vc_beat_t;

  // A BAR decode selects a channel when any of its bits overlap the mask.
  function automatic logic sonic_vc_bar_hit(input logic [SONIC_VC_BARDEC_W-1:0] bardec,
                                            input logic [SONIC_VC_BARDEC_W-1:0] mask);
    return |(bardec & mask);
  endfunction

endpackage

// File: rtl/sonic_vc_classifier_pipe.sv
// sonic_vc_classifier_pipe
// Single-entry ready/valid register. The payload is an opaque WIDTH-bit
// vector (the classifier packs the beat record plus its channel into it).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   in_valid/in_ready : upstream handshake; in_ready = out_ready || !out_valid
//   in_payload        : data captured when in_valid && in_ready
//   out_valid/out_ready, out_payload : registered downstream side
module sonic_vc_classifier_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_payload
);

  logic             valid_reg;
  logic [WIDTH-1:0] payload_reg;

  // Depends only on the output register and out_ready, never on in_valid,
  // so upstream sees no combinational loop through this stage.
  assign in_ready = out_ready || !valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg   <= 1'b0;
      payload_reg <= '0;
    end else if (in_ready) begin
      valid_reg <= in_valid;
      // Payload is left untouched when nothing loads so an emptied register
      // does not toggle the data bus needlessly.
      if (in_valid) begin
        payload_reg <= in_payload;
      end
    end
  end

  assign out_valid   = valid_reg;
  assign out_payload = payload_reg;

endmodule

// File: rtl/sonic_vc_classifier.sv
// sonic_vc_classifier
// Picks a virtual channel from the BAR decode at start-of-packet, holds it
// for the whole packet, discards unmatched and malformed traffic, and
// presents a registered stream with a per-packet out_channel for the demux.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   in_valid/in_ready, in_*       : upstream Avalon-ST beat + bardec/be sidebands
//   out_valid/out_ready, out_*    : registered beat, out_channel per packet
//   stats_clr, pkt_cnt0/1, drop_cnt, err_cnt : statistics
// Build option: define SONIC_VC_CLASSIFIER_STATS_EN to implement the
// counters; otherwise they read as zero and stats_clr is ignored.
module sonic_vc_classifier
  import sonic_vc_pkg::*;
#(
  parameter logic [SONIC_VC_BARDEC_W-1:0] CH1_BAR_MASK = 8'h04,
  parameter logic [SONIC_VC_BARDEC_W-1:0] CH0_BAR_MASK = 8'h01
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SONIC_VC_DATA_W-1:0]   in_data,
  input  logic                         in_startofpacket,
  input  logic                         in_endofpacket,
  input  logic                         in_empty,
  input  logic [SONIC_VC_BARDEC_W-1:0] in_bardec,
  input  logic [SONIC_VC_BE_W-1:0]     in_be,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_channel,
  output logic [SONIC_VC_DATA_W-1:0]   out_data,
  output logic                         out_startofpacket,
  output logic                         out_endofpacket,
  output logic                         out_empty,
  output logic [SONIC_VC_BARDEC_W-1:0] out_bardec,
  output logic [SONIC_VC_BE_W-1:0]     out_be,
  input  logic                         stats_clr,
  output logic [31:0]                  pkt_cnt0,
  output logic [31:0]                  pkt_cnt1,
  output logic [15:0]                  drop_cnt,
  output logic [15:0]                  err_cnt
);

  localparam int PIPE_W = $bits(sonic_vc_beat_t) + 1;

  sonic_vc_cls_state_t state_reg, state_next;
  logic                chan_reg, chan_next;

  sonic_vc_beat_t in_beat, out_beat;
  logic           accept, hit1, hit0;
  logic           fwd_beat, beat_chan;
  logic           drop_inc, err_inc, pkt0_inc, pkt1_inc;
  logic           pipe_in_ready;

  assign accept = in_valid && pipe_in_ready;
  assign hit1   = sonic_vc_bar_hit(in_bardec, CH1_BAR_MASK);
  assign hit0   = sonic_vc_bar_hit(in_bardec, CH0_BAR_MASK);

  assign in_beat = '{data: in_data, empty: in_empty, eop: in_endofpacket,
                     sop: in_startofpacket, bardec: in_bardec, be: in_be};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      chan_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      chan_reg  <= chan_next;
    end
  end

  // Next state. An SOP restarts classification from any state; otherwise an
  // EOP closes whatever packet is open (a stray EOP in IDLE stays in IDLE).
  always_comb begin
    state_next = state_reg;
    chan_next  = chan_reg;
    if (accept) begin
      if (in_startofpacket) begin
        if (hit1 || hit0) begin
          chan_next  = hit1;
          state_next = in_endofpacket ? IDLE : FWD;
        end else begin
          state_next = in_endofpacket ? IDLE : DROP;
        end
      end else if (in_endofpacket) begin
        state_next = IDLE;
      end
    end
  end

  // Per-beat actions. A forwarded SOP uses the freshly classified channel,
  // continuation beats use the latched one. A mid-packet SOP is both an
  // error and a fresh classification, so it may also count as a drop.
  always_comb begin
    fwd_beat  = 1'b0;
    beat_chan = chan_reg;
    drop_inc  = 1'b0;
    err_inc   = 1'b0;
    if (accept) begin
      if (in_startofpacket) begin
        err_inc = (state_reg != IDLE);
        if (hit1 || hit0) begin
          fwd_beat  = 1'b1;
          beat_chan = hit1;
        end else begin
          drop_inc = 1'b1;
        end
      end else begin
        err_inc  = (state_reg == IDLE);
        fwd_beat = (state_reg == FWD);
      end
    end
    pkt0_inc = fwd_beat && in_endofpacket && !beat_chan;
    pkt1_inc = fwd_beat && in_endofpacket &&  beat_chan;
  end

  sonic_vc_classifier_pipe #(
    .WIDTH (PIPE_W)
  ) u_pipe (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (fwd_beat),
    .in_ready    (pipe_in_ready),
    .in_payload  ({beat_chan, in_beat}),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload ({out_channel, out_beat})
  );

  assign in_ready          = pipe_in_ready;
  assign out_data          = out_beat.data;
  assign out_startofpacket = out_beat.sop;
  assign out_endofpacket   = out_beat.eop;
  assign out_empty         = out_beat.empty;
  assign out_bardec        = out_beat.bardec;
  assign out_be            = out_beat.be;

`ifdef SONIC_VC_CLASSIFIER_STATS_EN
  logic [31:0] pkt_cnt0_reg, pkt_cnt1_reg;
  logic [15:0] drop_cnt_reg, err_cnt_reg;

  // Clear takes priority over any increment in the same cycle. Packet
  // counters wrap; drop/error counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      pkt_cnt0_reg <= '0;
      pkt_cnt1_reg <= '0;
      drop_cnt_reg <= '0;
      err_cnt_reg  <= '0;
    end else begin
      if (pkt0_inc) pkt_cnt0_reg <= pkt_cnt0_reg + 32'd1;
      if (pkt1_inc) pkt_cnt1_reg <= pkt_cnt1_reg + 32'd1;
      if (drop_inc && (drop_cnt_reg != 16'hFFFF)) drop_cnt_reg <= drop_cnt_reg + 16'd1;
      if (err_inc  && (err_cnt_reg  != 16'hFFFF)) err_cnt_reg  <= err_cnt_reg  + 16'd1;
    end
  end

  assign pkt_cnt0 = pkt_cnt0_reg;
  assign pkt_cnt1 = pkt_cnt1_reg;
  assign drop_cnt = drop_cnt_reg;
  assign err_cnt  = err_cnt_reg;
`else
  // Statistics compiled out: event strobes and the clear have no consumer.
  logic unused_stats;
  assign unused_stats = ^{stats_clr, drop_inc, err_inc, pkt0_inc, pkt1_inc};

  assign pkt_cnt0 = '0;
  assign pkt_cnt1 = '0;
  assign drop_cnt = '0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_sonic_vc_classifier.sv
module tb_sonic_vc_classifier;

`ifdef SONIC_VC_CLASSIFIER_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [127:0] in_data;
  logic         in_startofpacket, in_endofpacket, in_empty;
  logic [7:0]   in_bardec;
  logic [15:0]  in_be;
  logic         out_valid, out_ready, out_channel;
  logic [127:0] out_data;
  logic         out_startofpacket, out_endofpacket, out_empty;
  logic [7:0]   out_bardec;
  logic [15:0]  out_be;
  logic         stats_clr;
  logic [31:0]  pkt_cnt0, pkt_cnt1;
  logic [15:0]  drop_cnt, err_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sonic_vc_classifier dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .in_empty(in_empty), .in_bardec(in_bardec), .in_be(in_be),
    .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
    .out_data(out_data), .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket), .out_empty(out_empty),
    .out_bardec(out_bardec), .out_be(out_be),
    .stats_clr(stats_clr), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
    .drop_cnt(drop_cnt), .err_cnt(err_cnt)
  );

  // Observed output beat / counters as flat vectors for compact comparison.
  logic [159:0] obs_vec, obs_cnt;
  assign obs_vec = {4'b0, out_channel, out_data, out_empty, out_endofpacket,
                    out_startofpacket, out_bardec, out_be};
  assign obs_cnt = {64'b0, pkt_cnt0, pkt_cnt1, drop_cnt, err_cnt};

  function automatic logic [159:0] mk(input logic ch, input logic [127:0] d,
                                      input logic emp, input logic eop, input logic sop,
                                      input logic [7:0] bd, input logic [15:0] be);
    return {4'b0, ch, d, emp, eop, sop, bd, be};
  endfunction

  function automatic logic [159:0] exp_cnt(input logic [31:0] p0, input logic [31:0] p1,
                                           input logic [15:0] dr, input logic [15:0] er);
    return STATS_ON ? {64'b0, p0, p1, dr, er} : 160'b0;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sop, input logic eop,
                       input logic [7:0] bd, input logic [127:0] d);
    in_valid = v; in_startofpacket = sop; in_endofpacket = eop;
    in_bardec = bd; in_data = d; in_be = d[15:0]; in_empty = d[0];
  endtask

  // Transaction log and capture of every beat handed to the demux.
  logic [159:0] rx_q[$];
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      rx_q.push_back(obs_vec);
      $display("rx ch=%0d sop=%0d eop=%0d bardec=%h data=%h",
               out_channel, out_startofpacket, out_endofpacket, out_bardec, out_data);
    end
  end

  typedef struct {
    logic       sop, eop;
    logic [7:0] bardec;
    logic       exp_fwd, exp_ch;
    int         p0, p1, dr, er;
  } row_t;
  row_t rows[16];

  // Reference model state for the random phase.
  logic [159:0] exp_q[$];
  int           m_mode;  // 0 between packets, 1 forwarding, 2 discarding
  logic         m_ch;
  logic [31:0]  m_p0, m_p1;
  logic [15:0]  m_dr, m_er;

  initial begin
    logic [127:0] d;
    logic         acc, fwd, ch, di, ei, pi0, pi1;

    //            sop eop bardec fwd ch  p0 p1 dr er
    rows[0]  = '{1'b1, 1'b0, 8'h04, 1'b1, 1'b1, 0, 0, 0, 0};
    rows[1]  = '{1'b0, 1'b0, 8'h04, 1'b1, 1'b1, 0, 0, 0, 0};
    rows[2]  = '{1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 0, 1, 0, 0};
    rows[3]  = '{1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 0, 1, 0, 0};
    rows[4]  = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1, 1, 0, 0};
    rows[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1, 1, 0};
    rows[6]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1, 1, 1, 0};
    rows[7]  = '{1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1, 1, 1, 1};
    rows[8]  = '{1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1, 1, 1, 1};
    rows[9]  = '{1'b1, 1'b0, 8'h05, 1'b1, 1'b1, 1, 1, 1, 2};
    rows[10] = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 1, 2, 1, 2};
    rows[11] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1, 2, 2, 2};
    rows[12] = '{1'b1, 1'b1, 8'h04, 1'b1, 1'b1, 1, 3, 2, 2};
    rows[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1, 3, 3, 2};
    rows[14] = '{1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1, 3, 3, 3};
    rows[15] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 2, 3, 3, 3};

    // ---------------- reset state ----------------
    reset = 1'b1; out_ready = 1'b0; stats_clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 128'h0);
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    chk("rst_out_valid", 160'(out_valid), 160'(1'b0));
    chk("rst_out_payload", obs_vec, 160'b0);
    chk("rst_counters", obs_cnt, 160'b0);
    chk("rst_in_ready", 160'(in_ready), 160'(1'b1));

    // ---------------- table: one beat per cycle, out_ready high ----------------
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d = {4{32'hC0DE_0000 | 32'(i)}};
      drive(1'b1, rows[i].sop, rows[i].eop, rows[i].bardec, d);
      #1;
      chk("tbl_in_ready", 160'(in_ready), 160'(1'b1));
      cyc();
      if (rows[i].exp_fwd) begin
        chk("tbl_valid", 160'(out_valid), 160'(1'b1));
        chk("tbl_beat", obs_vec, mk(rows[i].exp_ch, d, d[0], rows[i].eop, rows[i].sop,
                                    rows[i].bardec, d[15:0]));
      end else begin
        chk("tbl_drop_valid", 160'(out_valid), 160'(1'b0));
      end
      chk("tbl_counters", obs_cnt, exp_cnt(32'(rows[i].p0), 32'(rows[i].p1),
                                           16'(rows[i].dr), 16'(rows[i].er)));
    end

    // ---------------- backpressure during a 4-beat packet ----------------
    drive(1'b0, 1'b0, 1'b0, 8'h00, 128'h0);
    cyc(); cyc();
    rx_q.delete();
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 8'h04, 128'hD0);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 8'h04, 128'hD1);
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_ready_low", 160'(in_ready), 160'(1'b0));
      chk("bp_hold", obs_vec, mk(1'b1, 128'hD0, 1'b0, 1'b0, 1'b1, 8'h04, 16'h00D0));
      cyc();
    end
    chk("bp_in_ready_low", 160'(in_ready), 160'(1'b0));
    out_ready = 1'b1;
    cyc();
    drive(1'b1, 1'b0, 1'b0, 8'h04, 128'hD2);
    cyc();
    drive(1'b1, 1'b0, 1'b1, 8'h04, 128'hD3);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 128'h0);
    cyc(); cyc();
    chk("bp_count", 160'(rx_q.size()), 160'(4));
    for (int k = 0; k < 4 && k < rx_q.size(); k++) begin
      chk("bp_beat", rx_q[k], mk(1'b1, 128'hD0 + 128'(k), k[0], k == 3, k == 0,
                                 8'h04, 16'h00D0 + 16'(k)));
    end
    chk("bp_counters", obs_cnt, exp_cnt(32'd2, 32'd4, 16'd3, 16'd3));

    // ---------------- reset on beat 2 of 4 ----------------
    drive(1'b1, 1'b1, 1'b0, 8'h01, 128'hE0);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 8'h01, 128'hE1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_mid_valid", 160'(out_valid), 160'(1'b0));
    chk("rst_mid_in_ready", 160'(in_ready), 160'(1'b1));
    chk("rst_mid_counters", obs_cnt, 160'b0);
    drive(1'b1, 1'b0, 1'b0, 8'h01, 128'hE2);
    cyc();
    chk("rst_mid_drop3", 160'(out_valid), 160'(1'b0));
    drive(1'b1, 1'b0, 1'b1, 8'h01, 128'hE3);
    cyc();
    chk("rst_mid_drop4", 160'(out_valid), 160'(1'b0));
    drive(1'b0, 1'b0, 1'b0, 8'h00, 128'h0);
    cyc();
    chk("rst_mid_err", obs_cnt, exp_cnt(32'd0, 32'd0, 16'd0, 16'd2));

    // ---------------- stats_clr coinciding with an EOP ----------------
    drive(1'b1, 1'b1, 1'b1, 8'h04, 128'hF0);
    stats_clr = 1'b1;
    cyc();
    stats_clr = 1'b0;
    chk("clr_vs_eop", obs_cnt, 160'b0);
    chk("clr_beat_fwd", 160'(out_valid), 160'(1'b1));

`ifdef SONIC_VC_CLASSIFIER_STATS_EN
    // ---------------- drop counter saturation ----------------
    drive(1'b1, 1'b1, 1'b1, 8'h00, 128'h5A);
    repeat (65535) cyc();
    chk("drop_at_max", 160'(drop_cnt), 160'(16'hFFFF));
    cyc();
    chk("drop_saturate", 160'(drop_cnt), 160'(16'hFFFF));
    chk("drop_sat_valid", 160'(out_valid), 160'(1'b0));
`endif

    // ---------------- randomized traffic against reference model ----------------
    drive(1'b0, 1'b0, 1'b0, 8'h00, 128'h0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_q.delete();
    m_mode = 0; m_ch = 1'b0;
    m_p0 = '0; m_p1 = '0; m_dr = '0; m_er = '0;
    for (int c = 0; c < 1500; c++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      in_valid         = ($urandom_range(0, 9) < 7);
      in_startofpacket = ($urandom_range(0, 3) == 0);
      in_endofpacket   = ($urandom_range(0, 9) < 3);
      case ($urandom_range(0, 5))
        0: in_bardec = 8'h00;
        1: in_bardec = 8'h01;
        2: in_bardec = 8'h04;
        3: in_bardec = 8'h05;
        4: in_bardec = 8'h02;
        default: in_bardec = 8'($urandom);
      endcase
      in_data   = d;
      in_be     = 16'($urandom);
      in_empty  = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      stats_clr = ($urandom_range(0, 49) == 0);
      #1;
      chk("rand_in_ready", 160'(in_ready), 160'(out_ready || exp_q.size() == 0));
      acc = in_valid && (out_ready || exp_q.size() == 0);
      cyc();

      // Model: one-deep output queue and per-packet bookkeeping.
      if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      fwd = 1'b0; ch = m_ch; di = 1'b0; ei = 1'b0;
      if (acc) begin
        if (in_startofpacket) begin
          ei = (m_mode != 0);
          if ((in_bardec & 8'h04) != 0) begin fwd = 1'b1; ch = 1'b1; end
          else if ((in_bardec & 8'h01) != 0) begin fwd = 1'b1; ch = 1'b0; end
          else di = 1'b1;
          if (fwd) m_ch = ch;
          m_mode = in_endofpacket ? 0 : (fwd ? 1 : 2);
        end else begin
          ei  = (m_mode == 0);
          fwd = (m_mode == 1);
          if (in_endofpacket) m_mode = 0;
        end
        if (fwd) exp_q.push_back(mk(ch, in_data, in_empty, in_endofpacket,
                                    in_startofpacket, in_bardec, in_be));
      end
      pi0 = fwd && in_endofpacket && !ch;
      pi1 = fwd && in_endofpacket && ch;
      if (stats_clr) begin
        m_p0 = '0; m_p1 = '0; m_dr = '0; m_er = '0;
      end else begin
        if (pi0) m_p0 = m_p0 + 32'd1;
        if (pi1) m_p1 = m_p1 + 32'd1;
        if (di && m_dr != 16'hFFFF) m_dr = m_dr + 16'd1;
        if (ei && m_er != 16'hFFFF) m_er = m_er + 16'd1;
      end

      chk("rand_valid", 160'(out_valid), 160'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("rand_beat", obs_vec, exp_q[0]);
      chk("rand_counters", obs_cnt, exp_cnt(m_p0, m_p1, m_dr, m_er));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sonic_vc_classifier.md
# sonic_vc_classifier

Packet classifier placed directly upstream of the SONIC virtual-channel demultiplexer. It takes the PCIe RX Avalon-ST stream (128-bit data plus BAR-decode and byte-enable sidebands), selects a virtual channel from the BAR decode at start-of-packet, and holds that channel for the whole packet. It discards unmatched and malformed traffic and presents a registered stream with a per-packet `out_channel` that drives the demux `in_channel`.

## Interface
- `CH1_BAR_MASK`, default 8'h04: a SOP with `in_bardec & CH1_BAR_MASK` nonzero selects channel 1.
- `CH0_BAR_MASK`, default 8'h01: a SOP with a nonzero CH0 match, and no CH1 match, selects channel 0.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1, `in_ready` out 1: upstream handshake.
- `in_data` in 128, `in_startofpacket` in 1, `in_endofpacket` in 1, `in_empty` in 1: beat payload.
- `in_bardec` in 8, `in_be` in 16: custom sidebands.
- `out_valid` out 1, `out_ready` in 1: downstream handshake to the demux.
- `out_channel` out 1: channel of the current packet.
- `out_data` 128, `out_startofpacket` 1, `out_endofpacket` 1, `out_empty` 1, `out_bardec` 8, `out_be` 16: all outputs, carried through unchanged.
- `stats_clr` in 1, `pkt_cnt0` out 32, `pkt_cnt1` out 32, `drop_cnt` out 16, `err_cnt` out 16: statistics (see Configuration).

## Operation
- A beat is accepted when `in_valid && in_ready`. Only accepted beats advance state.
- State machine `IDLE`, `FWD`, `DROP`. Reset state is `IDLE`.
- **IDLE, SOP beat:**
  - Classify the beat: CH1 match gives channel 1; otherwise CH0 match gives channel 0; otherwise the beat is unmatched.
  - Matched: latch the channel, forward the beat, go to `FWD`. If `eop` is also set, stay in `IDLE`.
  - Unmatched: discard the beat, `drop_cnt++`, go to `DROP`. If `eop` is also set, stay in `IDLE`.
- **IDLE, non-SOP beat:** discard it, `err_cnt++`, stay in `IDLE`.
- **FWD:** forward each beat with the latched channel. EOP returns to `IDLE`.
  - SOP received while in `FWD`: `err_cnt++`, reclassify as in `IDLE`. The previous packet is left unterminated downstream, and the block does not synthesize an EOP.
- **DROP:** discard beats until EOP, then return to `IDLE`.
  - SOP received while in `DROP`: `err_cnt++`, reclassify.
- Discarded beats are always accepted, subject only to the `in_ready` rule.
- `pkt_cnt0` / `pkt_cnt1` increment on each forwarded EOP beat for the matching channel.
- Counter widths:
  - `pkt_cnt*` are 32 bits and wrap modulo 2^32.
  - `drop_cnt` and `err_cnt` are 16 bits and saturate at 16'hFFFF.
- `stats_clr` zeroes all four counters next cycle. If it coincides with an increment, the clear wins.

## Timing
- Output is one registered stage.
  - `in_ready = out_ready || !out_valid`, combinational from the output register only.
  - Latency is 1 cycle from acceptance to `out_valid`.
  - Full throughput: 1 beat/cycle when `out_ready` stays high.
- Output hold rule: while `out_valid && !out_ready`, all `out_*` hold stable.
- Discarded beats do not load the output register. If the register is empty, `out_valid` is 0 next cycle.
- Reset values:
  - `out_valid` = 0, and all `out_*` payload bits = 0.
  - State = `IDLE`, latched channel = 0, all counters = 0.
- `in_ready` is 1 the cycle after reset.
- Reset asserted mid-packet: the state machine and the output register clear on that edge, and any pending output beat is lost. The next non-SOP beat is counted as an error.

## Configuration
- `SONIC_VC_CLASSIFIER_STATS_EN`
  - Defined: the four counters are implemented as specified.
  - Undefined: `pkt_cnt0`, `pkt_cnt1`, `drop_cnt` and `err_cnt` are tied to 0 and `stats_clr` is ignored. Classification and dropping are unchanged.

## Structure
- Shared package `sonic_vc_pkg` holds:
  - `SONIC_VC_DATA_W` = 128, `SONIC_VC_BARDEC_W` = 8, `SONIC_VC_BE_W` = 16.
  - The `sonic_vc_cls_state_t` enum (`IDLE`, `FWD`, `DROP`).
  - A packed beat struct: data, empty, eop, sop, bardec, be.
- One sub-module, `sonic_vc_classifier_pipe`: a parameterized single-entry ready/valid register. It receives the beat struct plus channel; its `in_ready` rule is as above.

## Test plan
- Two SOP/EOP packets back-to-back:
  - 3 beats with `bardec`=8'h04 → `out_channel`=1 on all 3 beats.
  - Then 2 beats with `bardec`=8'h01 → `out_channel`=0.
  - Then `pkt_cnt1`=1, `pkt_cnt0`=1, 1 beat/cycle.
- 2-beat packet with `bardec`=8'h00 → nothing output, `drop_cnt`=1, `in_ready` stays 1.
- Non-SOP beat in `IDLE`, then SOP mid-packet with `bardec`=8'h05 → `err_cnt`=2; the new packet goes to channel 1 (CH1 has priority).
- `out_ready` low for 4 cycles during a 4-beat packet → `in_ready` low after the first beat is registered, output stable, no beats lost or duplicated.
- `reset` pulsed on beat 2 of 4 → `out_valid`=0 next cycle. The remaining beats 3–4 are counted as errors: `err_cnt`=2 after reset, with stats enabled.
- Stats edge cases:
  - Force `drop_cnt` to 16'hFFFF, then drop another packet → it stays 16'hFFFF.
  - Assert `stats_clr` together with an EOP → `pkt_cnt`=0.
